// File: rtl/keypad_entry_if.sv
// Keypad pins plus key-event and entry-buffer handshake for keypad_entry.
// master = the keypad_entry block, slave = keypad hardware and consumer side.
interface keypad_entry_if #(
   parameter int DIGITS = 5
);
   logic [3:0]          col_n;
   logic [3:0]          row_n;
   logic [3:0]          key_code;
   logic                key_valid;
   logic [4*DIGITS-1:0] digits;
   logic [3:0]          count;
   logic                entry_valid;
   logic                entry_ack;

   modport master (
      output col_n, key_code, key_valid, digits, count, entry_valid,
      input  row_n, entry_ack
   );

   modport slave (
      input  col_n, key_code, key_valid, digits, count, entry_valid,
      output row_n, entry_ack
   );
endinterface

// File: rtl/keypad_entry.sv
// Column-scanned 4x4 keypad with frame debounce, ghost rejection and a
// hex-digit entry buffer that locks on enter until acknowledged.
module keypad_entry #(
   parameter int SCAN_CYCLES    = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int DIGITS         = 5
) (
   input logic           clk,
   input logic           rst_n,
   keypad_entry_if.master bus
);

   localparam int SW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int BW = 4 * DIGITS;

   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DB_TARGET = DW'(DEBOUNCE_SCANS);
   localparam logic [3:0]    FULL      = 4'(DIGITS);

   typedef enum logic {
      RELEASED,
      PRESSED
   } deb_state_t;

   deb_state_t      state;
   logic [SW-1:0]   slot;
   logic [1:0]      col;
   logic [3:0]      col_n_q;
   logic [1:0]      frame_lows;
   logic [3:0]      frame_key;
   logic            cand_valid;
   logic [3:0]      cand_code;
   logic [DW-1:0]   run;
   logic [3:0]      key_code_q;
   logic            key_valid_q;
   logic [BW-1:0]   digits_q;
   logic [3:0]      count_q;
   logic            locked;

   logic [3:0]      row_low;
   logic [1:0]      row_idx;
   logic [2:0]      col_lows;
   logic [2:0]      lows_sum;
   logic [1:0]      lows_sat;
   logic [3:0]      col_key;
   logic            res_valid;
   logic [3:0]      res_code;
   logic [DW-1:0]   run_inc;
   logic [DW-1:0]   run_match;

   function automatic logic [3:0] key_at(input logic [1:0] c, input logic [1:0] r);
      logic [3:0] k;
      case ({c, r})
         4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'h0;
         4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'hF;
         4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
         4'hC: k = 4'hA;  4'hD: k = 4'hB;  4'hE: k = 4'hC;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] d, input logic [3:0] k);
      logic [BW-1:0] r;
      r      = d << 4;
      r[3:0] = k;
      return r;
   endfunction

   // row_n is expected to arrive already synchronised to clk
   assign row_low  = ~bus.row_n;
   assign col_lows = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
   assign lows_sum = {1'b0, frame_lows} + col_lows;
   assign lows_sat = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
   assign col_key  = key_at(col, row_idx);

   always_comb begin
      row_idx = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (row_low[r]) row_idx = 2'(r);
      end
   end

   // Frame result includes the column-3 sample taken in the same cycle
   assign res_valid = (lows_sum == 3'd1);
   assign res_code  = (frame_lows == 2'd1) ? frame_key : col_key;
   assign run_inc   = run + DW'(1);
   assign run_match = (res_valid && cand_valid && res_code == cand_code) ? run_inc : DW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RELEASED;
         slot        <= '0;
         col         <= 2'd0;
         col_n_q     <= 4'b1110;
         frame_lows  <= 2'd0;
         frame_key   <= 4'h0;
         cand_valid  <= 1'b0;
         cand_code   <= 4'h0;
         run         <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (slot == SLOT_LAST) begin
            slot    <= '0;
            col     <= col + 2'd1;
            col_n_q <= {col_n_q[2:0], col_n_q[3]};
            if (col == 2'd3) begin
               frame_lows <= 2'd0;
               frame_key  <= 4'h0;
               case (state)
                  RELEASED: begin
                     cand_valid <= res_valid;
                     cand_code  <= res_valid ? res_code : 4'h0;
                     if (res_valid && run_match == DB_TARGET) begin
                        state       <= PRESSED;
                        key_code_q  <= res_code;
                        key_valid_q <= 1'b1;
                        run         <= '0;
                     end else begin
                        run <= run_match;
                     end
                  end
                  PRESSED: begin
                     if (res_valid) begin
                        run <= '0;
                     end else if (run_inc == DB_TARGET) begin
                        state      <= RELEASED;
                        run        <= '0;
                        cand_valid <= 1'b0;
                        cand_code  <= 4'h0;
                     end else begin
                        run <= run_inc;
                     end
                  end
                  default: state <= RELEASED;
               endcase
            end else begin
               frame_lows <= lows_sat;
               if (col_lows == 3'd1) frame_key <= col_key;
            end
         end else begin
            slot <= slot + SW'(1);
         end
      end
   end

   // A pending acknowledge outranks any key arriving while locked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q <= '0;
         count_q  <= 4'd0;
         locked   <= 1'b0;
      end else if (locked) begin
         if (bus.entry_ack) begin
            locked   <= 1'b0;
            digits_q <= '0;
            count_q  <= 4'd0;
         end
      end else if (key_valid_q) begin
         case (key_code_q)
            4'hC: begin
               digits_q <= '0;
               count_q  <= 4'd0;
            end
            4'hD: begin
               if (count_q != 4'd0) begin
                  digits_q <= digits_q >> 4;
                  count_q  <= count_q - 4'd1;
               end
            end
            4'hE: begin
               if (count_q == FULL) locked <= 1'b1;
            end
            4'hA, 4'hB, 4'hF: begin
            end
            default: begin
               if (count_q < FULL) begin
                  digits_q <= shift_in(digits_q, key_code_q);
                  count_q  <= count_q + 4'd1;
               end
            end
         endcase
      end
   end

   assign bus.col_n       = col_n_q;
   assign bus.key_code    = key_code_q;
   assign bus.key_valid   = key_valid_q;
   assign bus.digits      = digits_q;
   assign bus.count       = count_q;
   assign bus.entry_valid = locked;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad switch model drives row_n from col_n and a
// frame-level reference model predicts key events and the entry buffer.
module tb_keypad_entry;

   localparam int SC    = 4;
   localparam int DB    = 2;
   localparam int DG    = 4;
   localparam int FRAME = 4 * SC;
   localparam int KEYMAP [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15},
                                    '{3, 6, 9, 14}, '{10, 11, 12, 13}};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] keys = '0;

   int tests = 0;
   int failures = 0;

   int         hist[$];
   bit         pressed_m;
   int         q[$];
   bit         locked_m;
   bit         pend_v;
   logic [3:0] pend_code;
   bit         ack_carry;

   keypad_entry_if #(.DIGITS(DG)) bus ();

   keypad_entry #(
      .SCAN_CYCLES(SC),
      .DEBOUNCE_SCANS(DB),
      .DIGITS(DG)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   // Closed switches short the selected column onto their row
   always_comb begin
      bus.row_n = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!bus.col_n[c] && keys[KEYMAP[c][r]]) bus.row_n[r] = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] expDigits();
      logic [31:0] v = '0;
      foreach (q[k]) v = (v << 4) | 32'(q[k]);
      return v;
   endfunction

   function automatic int frameResult(input logic [15:0] m);
      if ($countones(m) != 1) return -1;
      for (int k = 0; k < 16; k++) if (m[k]) return k;
      return -1;
   endfunction

   task automatic modelReset();
      hist.delete();
      pressed_m = 0;
      q.delete();
      locked_m  = 0;
      pend_v    = 0;
      pend_code = 4'h0;
      ack_carry = 0;
   endtask

   // A press is accepted once the last DB frames since the previous transition
   // show the same single key; a release needs DB empty frames likewise.
   task automatic debounceModel(input int res, output bit ev, output logic [3:0] code);
      bit same;
      ev   = 0;
      code = 4'h0;
      hist.push_back(res);
      if (hist.size() >= DB) begin
         same = 1;
         for (int k = 0; k < DB; k++) if (hist[hist.size() - 1 - k] != res) same = 0;
         if (!pressed_m && same && res >= 0) begin
            pressed_m = 1;
            ev        = 1;
            code      = 4'(res);
            hist.delete();
         end else if (pressed_m && same && res < 0) begin
            pressed_m = 0;
            hist.delete();
         end
      end
   endtask

   task automatic modelEdit(input bit ack, input bit ev, input logic [3:0] code);
      if (locked_m) begin
         if (ack) begin
            q.delete();
            locked_m = 0;
         end
      end else if (ev) begin
         if (code <= 4'd9) begin
            if (q.size() < DG) q.push_back(int'(code));
         end else if (code == 4'hD) begin
            if (q.size() > 0) void'(q.pop_back());
         end else if (code == 4'hC) begin
            q.delete();
         end else if (code == 4'hE) begin
            if (q.size() == DG) locked_m = 1;
         end
      end
   endtask

   task automatic checkBuffer();
      checkOutput("digits", 32'(bus.digits), expDigits());
      checkOutput("count", 32'(bus.count), 32'(q.size()));
      checkOutput("entry_valid", 32'(bus.entry_valid), 32'(locked_m));
   endtask

   task automatic checkReset();
      checkOutput("rst_col_n", 32'(bus.col_n), 32'h0000_000E);
      checkOutput("rst_key_code", 32'(bus.key_code), 32'h0);
      checkOutput("rst_key_valid", 32'(bus.key_valid), 32'h0);
      checkOutput("rst_digits", 32'(bus.digits), 32'h0);
      checkOutput("rst_count", 32'(bus.count), 32'h0);
      checkOutput("rst_entry_valid", 32'(bus.entry_valid), 32'h0);
   endtask

   task automatic doReset(input logic [15:0] m);
      keys          = m;
      bus.entry_ack = 1'b0;
      rst_n         = 1'b0;
      #1;
      checkReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   // One full scan frame; ack_iter raises entry_ack for the edge after that step
   task automatic runFrame(input logic [15:0] m, input int ack_iter, input bit check_cols);
      int         pulses = 0;
      logic [3:0] seen = 4'h0;
      logic [3:0] ec;
      bit         ack_now, ev_now, exp_ev;
      logic [3:0] exp_code;
      keys = m;
      for (int i = 0; i < FRAME; i++) begin
         ack_now = (i == 0) ? ack_carry : (ack_iter == i - 1);
         ev_now  = (i == 0) && pend_v;
         @(posedge clk);
         modelEdit(ack_now, ev_now, pend_code);
         #1;
         bus.entry_ack = (i == ack_iter);
         if (bus.key_valid) begin
            pulses++;
            seen = bus.key_code;
         end
         if (check_cols) begin
            ec = 4'b1111;
            ec[((i + 1) / SC) % 4] = 1'b0;
            checkOutput("col_n", 32'(bus.col_n), 32'(ec));
         end
         if (i == 0 || i == ack_iter + 1) checkBuffer();
      end
      ack_carry = (ack_iter == FRAME - 1);
      debounceModel(frameResult(m), exp_ev, exp_code);
      checkOutput("key_valid_pulses", 32'(pulses), 32'(exp_ev));
      if (exp_ev) checkOutput("key_code", 32'(seen), 32'(exp_code));
      pend_v    = exp_ev;
      pend_code = exp_code;
   endtask

   task automatic applyStimulus(input logic [15:0] m, input int nframes, input int ack_iter);
      for (int f = 0; f < nframes; f++) runFrame(m, (f == 0) ? ack_iter : -1, 1'b0);
   endtask

   task automatic press(input int code);
      logic [15:0] m = '0;
      m[code] = 1'b1;
      applyStimulus(m, DB, -1);
      applyStimulus(16'h0, DB, -1);
   endtask

   initial begin
      logic [15:0] m;
      int a, b, kind;
      bus.entry_ack = 1'b0;
      modelReset();
      #2;

      // Key 5 held through reset release: one event after DB frames
      doReset(16'h0020);
      for (int f = 0; f < 4; f++) runFrame(16'h0020, -1, f < 2);
      checkOutput("plan_key_code_5", 32'(bus.key_code), 32'h5);
      applyStimulus(16'h0, 3, -1);

      // Bouncing key 3, then steady
      for (int f = 0; f < 6; f++) runFrame((f % 2 == 0) ? 16'h0008 : 16'h0000, -1, 1'b0);
      applyStimulus(16'h0008, DB, -1);
      applyStimulus(16'h0, DB, -1);

      // Two keys at once are rejected
      applyStimulus(16'h0006, 5, -1);
      applyStimulus(16'h0, DB, -1);

      // Editing sequence
      press(12);
      for (int k = 1; k <= 5; k++) press(k);
      checkOutput("plan_digits_1234", 32'(bus.digits), 32'h1234);
      checkOutput("plan_count_4", 32'(bus.count), 32'h4);
      press(13);
      checkOutput("plan_digits_0123", 32'(bus.digits), 32'h0123);
      press(14);
      checkOutput("plan_enter_short", 32'(bus.entry_valid), 32'h0);
      press(9);
      press(14);
      checkOutput("plan_digits_1239", 32'(bus.digits), 32'h1239);
      checkOutput("plan_locked", 32'(bus.entry_valid), 32'h1);
      press(7);
      press(12);
      checkOutput("plan_locked_digits", 32'(bus.digits), 32'h1239);
      applyStimulus(16'h0, 1, 5);
      checkOutput("plan_ack_valid", 32'(bus.entry_valid), 32'h0);
      checkOutput("plan_ack_digits", 32'(bus.digits), 32'h0);

      // Ack and key event in the same cycle while locked
      for (int k = 1; k <= 4; k++) press(k);
      press(14);
      runFrame(16'h0002, -1, 1'b0);
      runFrame(16'h0002, FRAME - 1, 1'b0);
      applyStimulus(16'h0, DB, -1);
      checkOutput("plan_collide_count", 32'(bus.count), 32'h0);
      checkOutput("plan_collide_valid", 32'(bus.entry_valid), 32'h0);

      // Asynchronous reset mid-slot while a key is pressed
      press(4);
      press(6);
      applyStimulus(16'h0400, DB, -1);
      keys = 16'h0400;
      repeat (5) @(posedge clk);
      #3;
      checkOutput("pre_rst_count", 32'(bus.count), 32'h2);
      checkOutput("pre_rst_key_code", 32'(bus.key_code), 32'hA);
      doReset(16'h0400);
      applyStimulus(16'h0400, 3, -1);
      applyStimulus(16'h0, DB, -1);

      // Randomised key traffic with occasional acknowledges
      for (int s = 0; s < 30; s++) begin
         kind = int'($urandom_range(0, 3));
         m    = '0;
         if (kind == 1 || kind == 2) m[$urandom_range(0, 15)] = 1'b1;
         if (kind == 3) begin
            a = int'($urandom_range(0, 15));
            b = (a + int'($urandom_range(1, 15))) % 16;
            m[a] = 1'b1;
            m[b] = 1'b1;
         end
         applyStimulus(m, int'($urandom_range(1, 4)),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1);
      end
      applyStimulus(16'h0, DB + 1, -1);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
